ls_counter_param: RTL

Parametrised successor to the team's 4-bit synchronous '163-style counter. Adds configurable width and modulus, up/down counting, wrap or saturate at the ends, a registered terminal-count pulse and an asynchronous reset. It is a drop-in cascadable counter for lab timing chains, dividers and address generators, with the same ent/enp/rco cascade convention.

---
 rtl/ls_counter_param.sv | 77 +++++++
 1 files changed

// File: rtl/ls_counter_param.sv
// Parametrised cascadable up/down counter ('163 lineage): sync clear/load,
// modulo-MODULUS wrap or saturate, combinational rco, registered tc pulse.
module ls_counter_param #(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter bit     SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic             ent,
    input  logic             enp,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rco,
    output logic             tc_pulse
);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("ls_counter_param: WIDTH must be 1..32");
        end
        if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_mod
            $error("ls_counter_param: MODULUS must be 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] term;
    logic             at_term;
    logic             step;

    assign term    = up ? MAXV : '0;
    assign at_term = (count_q == term);
    // Count step only when neither clear nor load wins the edge.
    assign step    = clear & load & ent & enp;

    always_comb begin
        count_d = count_q;
        if (!clear) begin
            count_d = '0;
        end else if (!load) begin
            count_d = (d > MAXV) ? MAXV : d;
        end else if (ent && enp) begin
            if (up) begin
                if (at_term) count_d = SATURATE ? count_q : '0;
                else         count_d = count_q + 1'b1;
            end else begin
                if (at_term) count_d = SATURATE ? count_q : MAXV;
                else         count_d = count_q - 1'b1;
            end
        end
    end

    // Fires on every enabled step at the end value, even when saturated.
    assign tc_d = step & at_term;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign q        = count_q;
    assign tc_pulse = tc_q;
    assign rco      = ent & at_term;

endmodule
